vfat_sbit_gate: RTL and testbench
=================================

Name: vfat_sbit_gate

Overview:
- Per-VFAT stage directly downstream of the frame aligner.
- Consumes the aligner's bitslipped 64-bit S-bit frame and its alignment status (sot_is_aligned, sot_unstable).
- Zeroes S-bits from unaligned, unstable or masked VFATs, then applies a programmable per-channel deadtime (one-shot) to suppress retriggers.
- Keeps a saturating activity counter for monitoring; output feeds the cluster-finding logic.

Parameters:
MXSBITS, 64, number of S-bit channels per VFAT
DT_BITS, 4, width of the deadtime setting and of each per-channel deadtime counter
CNT_BITS, 24, width of the activity counter

Ports:
clock  input  1  40 MHz fabric clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
sbits_i  input  MXSBITS  aligned S-bit frame from the frame aligner
sot_is_aligned_i  input  1  aligner reports SoT stable for the ready count
sot_unstable_i  input  1  sticky aligner flag: SoT lost after alignment
mask_i  input  1  software mask for this VFAT
deadtime_i  input  DT_BITS  per-channel deadtime in clocks; 0 = no deadtime
cnt_reset_i  input  1  synchronous clear of the activity counter
sbits_o  output  MXSBITS  gated, deadtimed S-bits
active_o  output  1  OR of sbits_o, same cycle as sbits_o
sbit_cnt_o  output  CNT_BITS  saturating count of cycles with active_o=1

Behaviour:
- Stage 1, input register:
  - sbits_r <= sbits_i.
  - en_r <= sot_is_aligned_i & ~sot_unstable_i & ~mask_i.
  - Both are sampled in the same cycle.
- Stage 2, per-channel one-shot. Each channel c has a DT_BITS counter dt[c]:
  - If en_r=0: sbits_o[c] <= 0 and dt[c] <= 0. This clears all counters, including mid-deadtime.
  - Else if dt[c]!=0: sbits_o[c] <= 0 and dt[c] <= dt[c]-1. Input is ignored.
  - Else (dt[c]=0): sbits_o[c] <= sbits_r[c]. If sbits_r[c]=1, dt[c] <= deadtime_i; otherwise dt[c] stays 0.
- Resulting timing:
  - A pulse at cycle t with deadtime N>0 suppresses channel c for cycles t+1..t+N.
  - A hit at t+N+1 produces a new pulse.
  - N=0 gives pure pass-through gated by en_r, so a continuously high input gives a continuous output.
- deadtime_i is sampled only when a counter is loaded. Changing it does not affect running counters.
- Channels are fully independent; no cross-channel interaction.
- Latency: sbits_i at cycle t appears on sbits_o at t+2. The same holds for the enable inputs.
- active_o is registered alongside sbits_o: active_o <= |(next sbits_o value). There is no extra latency relative to sbits_o.
- Activity counter (sbit_cnt_o):
  - Increments by 1 on the clock after a cycle with active_o=1.
  - Saturates at 2^CNT_BITS-1 and never wraps.
  - cnt_reset_i=1 forces 0 on the next edge and takes priority over an increment in the same cycle.
- Reset:
  - sbits_r, en_r, every dt[c], sbits_o, active_o and sbit_cnt_o all go to 0 on the next edge.
  - Reset mid-deadtime clears the deadtime.
  - After reset deasserts, the first possible nonzero sbits_o is 2 cycles after the first enabled, nonzero sbits_i.

Test Plan:
- Enabled, deadtime_i=0, sbits_i=64'h1 for 3 cycles at t..t+2 -> sbits_o=64'h1 at t+2..t+4, active_o=1 for those 3 cycles, sbit_cnt_o=3 afterwards.
- Enabled, deadtime_i=3, sbits_i[5] held high continuously from t -> sbits_o[5] pulses at t+2, t+6, t+10 (period 4); other bits remain 0.
- Enabled, deadtime_i=2, pulse ch0 at t, pulse ch1 at t+1 -> sbits_o[0] at t+2 and sbits_o[1] at t+3, independently; a ch0 hit at t+2 is suppressed and one at t+3 passes (sbits_o[0] at t+5).
- Enabled, deadtime_i=15, ch7 fires, then sot_unstable_i=1 for one cycle mid-deadtime and returns to 0 -> output 0 while disabled; dt cleared, so the next ch7 hit after re-enable passes immediately. Repeat with mask_i and with sot_is_aligned_i=0: same behaviour.
- Preload the counter near saturation (CNT_BITS=4 build), drive 20 active cycles -> sbit_cnt_o stops at 15. Assert cnt_reset_i in the same cycle as active_o=1 -> counter reads 0 next cycle.
- Reset asserted during active traffic with running deadtimes -> all outputs 0 next edge. After release with input held high, sbits_o goes high exactly 2 cycles after the first sampled enabled input.

Source files
------------

// File: rtl/vfat_sbit_gate_if.sv
// Per-VFAT S-bit gate bus: aligned frame plus alignment status in, gated frame and activity out.
// The "master" side drives the frame and controls, the "slave" side is the gate itself.
interface vfat_sbit_gate_if #(
    parameter int MXSBITS  = 64,
    parameter int DT_BITS  = 4,
    parameter int CNT_BITS = 24
);
    logic [MXSBITS-1:0]  sbits_i;
    logic                sot_is_aligned_i;
    logic                sot_unstable_i;
    logic                mask_i;
    logic [DT_BITS-1:0]  deadtime_i;
    logic                cnt_reset_i;
    logic [MXSBITS-1:0]  sbits_o;
    logic                active_o;
    logic [CNT_BITS-1:0] sbit_cnt_o;

    modport master (
        output sbits_i, sot_is_aligned_i, sot_unstable_i, mask_i, deadtime_i, cnt_reset_i,
        input  sbits_o, active_o, sbit_cnt_o
    );

    modport slave (
        input  sbits_i, sot_is_aligned_i, sot_unstable_i, mask_i, deadtime_i, cnt_reset_i,
        output sbits_o, active_o, sbit_cnt_o
    );
endinterface

// File: rtl/vfat_sbit_gate.sv
// Zeroes S-bits from unaligned/unstable/masked VFATs, applies a per-channel one-shot deadtime,
// and keeps a saturating count of active cycles for monitoring.
module vfat_sbit_gate #(
    parameter int MXSBITS  = 64,
    parameter int DT_BITS  = 4,
    parameter int CNT_BITS = 24
) (
    input logic              clock,
    input logic              reset,
    vfat_sbit_gate_if.slave  bus
);

    logic [MXSBITS-1:0]  sbits_reg;
    logic                en_reg;
    logic [MXSBITS-1:0]  sbits_next;
    logic [MXSBITS-1:0]  sbits_o_reg;
    logic                active_reg;
    logic [CNT_BITS-1:0] cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sbits_reg <= '0;
            en_reg    <= 1'b0;
        end else begin
            sbits_reg <= bus.sbits_i;
            en_reg    <= bus.sot_is_aligned_i & ~bus.sot_unstable_i & ~bus.mask_i;
        end
    end

    // Each channel owns its deadtime counter; a disabled VFAT clears every counter at once.
    for (genvar gi = 0; gi < MXSBITS; gi++) begin : g_chan
        logic [DT_BITS-1:0] dt_reg;

        always_ff @(posedge clock) begin
            if (reset || !en_reg) begin
                dt_reg <= '0;
            end else if (dt_reg != '0) begin
                dt_reg <= dt_reg - 1'b1;
            end else if (sbits_reg[gi]) begin
                dt_reg <= bus.deadtime_i;
            end
        end

        assign sbits_next[gi] = en_reg & (dt_reg == '0) & sbits_reg[gi];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sbits_o_reg <= '0;
            active_reg  <= 1'b0;
        end else begin
            sbits_o_reg <= sbits_next;
            active_reg  <= |sbits_next;
        end
    end

    // Clear wins over increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset || bus.cnt_reset_i) begin
            cnt_reg <= '0;
        end else if (active_reg && (cnt_reg != {CNT_BITS{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bus.sbits_o    = sbits_o_reg;
    assign bus.active_o   = active_reg;
    assign bus.sbit_cnt_o = cnt_reg;

endmodule

// File: tb/tb_vfat_sbit_gate.sv
// Randomised and directed checks of vfat_sbit_gate against a time-stamp model of the deadtime rule.
// A second instance with a 4-bit counter exercises counter saturation.
module tb_vfat_sbit_gate;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [63:0] sb_drv;
    logic        al_drv, un_drv, mk_drv, crst_drv;
    logic [3:0]  dt_drv;

    vfat_sbit_gate_if #(.MXSBITS(64), .DT_BITS(4), .CNT_BITS(24)) bus_a ();
    vfat_sbit_gate_if #(.MXSBITS(64), .DT_BITS(4), .CNT_BITS(4))  bus_s ();

    assign bus_a.sbits_i = sb_drv;          assign bus_s.sbits_i = sb_drv;
    assign bus_a.sot_is_aligned_i = al_drv; assign bus_s.sot_is_aligned_i = al_drv;
    assign bus_a.sot_unstable_i = un_drv;   assign bus_s.sot_unstable_i = un_drv;
    assign bus_a.mask_i = mk_drv;           assign bus_s.mask_i = mk_drv;
    assign bus_a.deadtime_i = dt_drv;       assign bus_s.deadtime_i = dt_drv;
    assign bus_a.cnt_reset_i = crst_drv;    assign bus_s.cnt_reset_i = crst_drv;

    vfat_sbit_gate #(.MXSBITS(64), .DT_BITS(4), .CNT_BITS(24)) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a.slave));
    vfat_sbit_gate #(.MXSBITS(64), .DT_BITS(4), .CNT_BITS(4)) dut_s (
        .clock(clock), .reset(reset), .bus(bus_s.slave));

    int vectors = 0;
    int errors  = 0;

    // Reference model: a channel is blocked up to and including cycle blocked[c].
    int          cyc = 0;
    int          blocked [64];
    logic [63:0] m_sr, m_out;
    logic        m_en, m_act;
    logic [23:0] m_cnt;
    logic [3:0]  m_cnt_s;

    task automatic tick();
        logic [63:0] nout;
        @(posedge clock);
        cyc++;
        if (reset) begin
            m_sr = '0; m_en = 1'b0; m_out = '0; m_act = 1'b0; m_cnt = '0; m_cnt_s = '0;
            for (int c = 0; c < 64; c++) blocked[c] = cyc;
        end else begin
            nout = '0;
            for (int c = 0; c < 64; c++) begin
                if (!m_en) begin
                    blocked[c] = cyc;
                end else if (m_sr[c] && cyc > blocked[c]) begin
                    nout[c] = 1'b1;
                    blocked[c] = cyc + int'(dt_drv);
                end
            end
            if (crst_drv) begin
                m_cnt = '0; m_cnt_s = '0;
            end else if (m_act) begin
                if (m_cnt != 24'hFFFFFF) m_cnt = m_cnt + 24'd1;
                if (m_cnt_s != 4'hF) m_cnt_s = m_cnt_s + 4'd1;
            end
            m_out = nout;
            m_act = |nout;
            m_sr  = sb_drv;
            m_en  = al_drv & ~un_drv & ~mk_drv;
        end
        #1;
    endtask

    task automatic flush();
        sb_drv = '0; al_drv = 1'b0; un_drv = 1'b0; mk_drv = 1'b0; crst_drv = 1'b1;
        repeat (3) tick();
        al_drv = 1'b1; crst_drv = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; sb_drv = 64'hFFFF_0000_FFFF_0001; al_drv = 1'b1; dt_drv = 4'd0;
        repeat (3) tick();
        vectors++;
        if (bus_a.sbits_o !== 64'h0 || bus_a.active_o !== 1'b0 || bus_a.sbit_cnt_o !== 24'h0) begin
            errors++;
            $display("FAIL reset: sbits_o=%h active_o=%b cnt=%0d, want 0/0/0",
                     bus_a.sbits_o, bus_a.active_o, bus_a.sbit_cnt_o);
        end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_passthrough();
        logic [63:0] seen [1:6];
        flush();
        dt_drv = 4'd0;
        for (int i = 1; i <= 6; i++) begin
            sb_drv = (i <= 3) ? 64'h1 : 64'h0;
            tick();
            seen[i] = bus_a.sbits_o;
            vectors++;
            if (bus_a.sbits_o !== m_out || bus_a.active_o !== m_act) begin
                errors++;
                $display("FAIL passthrough[%0d]: sbits_o=%h active_o=%b, want %h/%b",
                         i, bus_a.sbits_o, bus_a.active_o, m_out, m_act);
            end
        end
        vectors++;
        if (seen[1] !== 64'h0 || seen[2] !== 64'h1 || seen[3] !== 64'h1 || seen[4] !== 64'h1 ||
            seen[5] !== 64'h0 || bus_a.sbit_cnt_o !== 24'd3) begin
            errors++;
            $display("FAIL passthrough_shape: out2..5=%h %h %h %h cnt=%0d, want 1 1 1 0 cnt=3",
                     seen[2], seen[3], seen[4], seen[5], bus_a.sbit_cnt_o);
        end
        $display("test_passthrough done");
    endtask

    task automatic test_deadtime_hold();
        int pulses [$];
        flush();
        dt_drv = 4'd3; sb_drv = 64'h20;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus_a.sbits_o[5]) pulses.push_back(i);
            vectors++;
            if (bus_a.sbits_o !== m_out) begin
                errors++;
                $display("FAIL deadtime_hold[%0d]: sbits_o=%h, want %h", i, bus_a.sbits_o, m_out);
            end
        end
        vectors++;
        if (pulses.size() != 3 || pulses[0] != 2 || pulses[1] != 6 || pulses[2] != 10 ||
            (bus_a.sbits_o & ~64'h20) !== 64'h0) begin
            errors++;
            $display("FAIL deadtime_period: %0d pulses, first at %0d, want 3 pulses at 2,6,10",
                     pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
        end
        $display("test_deadtime_hold done");
    endtask

    task automatic test_independent();
        logic [63:0] stim [1:6];
        logic [63:0] want [1:6];
        stim = '{64'h1, 64'h2, 64'h1, 64'h1, 64'h0, 64'h0};
        want = '{64'h0, 64'h1, 64'h2, 64'h0, 64'h1, 64'h0};
        flush();
        dt_drv = 4'd2;
        for (int i = 1; i <= 6; i++) begin
            sb_drv = stim[i];
            tick();
            vectors++;
            if (bus_a.sbits_o !== want[i] || bus_a.sbits_o !== m_out) begin
                errors++;
                $display("FAIL independent[%0d]: sbits_o=%h, want %h", i, bus_a.sbits_o, want[i]);
            end
        end
        $display("test_independent done");
    endtask

    task automatic test_disable();
        for (int mode = 0; mode < 3; mode++) begin
            int hits;
            flush();
            dt_drv = 4'd15; hits = 0;
            for (int i = 1; i <= 10; i++) begin
                sb_drv = (i == 1 || i == 7) ? 64'h80 : 64'h0;
                un_drv = (mode == 0 && i == 5);
                mk_drv = (mode == 1 && i == 5);
                al_drv = !(mode == 2 && i == 5);
                tick();
                if (bus_a.sbits_o[7]) hits++;
                vectors++;
                if (bus_a.sbits_o !== m_out) begin
                    errors++;
                    $display("FAIL disable_m%0d[%0d]: sbits_o=%h, want %h",
                             mode, i, bus_a.sbits_o, m_out);
                end
            end
            vectors++;
            if (hits != 2) begin
                errors++;
                $display("FAIL disable_rearm_m%0d: %0d ch7 pulses, want 2", mode, hits);
            end
        end
        $display("test_disable done");
    endtask

    task automatic test_saturation();
        flush();
        dt_drv = 4'd0; sb_drv = 64'h1;
        for (int i = 1; i <= 22; i++) begin
            tick();
            vectors++;
            if (bus_s.sbit_cnt_o !== m_cnt_s) begin
                errors++;
                $display("FAIL sat[%0d]: cnt=%0d, want %0d", i, bus_s.sbit_cnt_o, m_cnt_s);
            end
        end
        vectors++;
        if (bus_s.sbit_cnt_o !== 4'd15 || bus_a.sbit_cnt_o !== 24'd20) begin
            errors++;
            $display("FAIL sat_level: small=%0d wide=%0d, want 15/20",
                     bus_s.sbit_cnt_o, bus_a.sbit_cnt_o);
        end
        crst_drv = 1'b1;
        tick();
        vectors++;
        if (bus_s.sbit_cnt_o !== 4'd0 || bus_a.sbit_cnt_o !== 24'd0 || bus_a.active_o !== 1'b1) begin
            errors++;
            $display("FAIL cnt_reset_priority: small=%0d wide=%0d active=%b, want 0/0/1",
                     bus_s.sbit_cnt_o, bus_a.sbit_cnt_o, bus_a.active_o);
        end
        crst_drv = 1'b0;
        tick();
        vectors++;
        if (bus_s.sbit_cnt_o !== 4'd1) begin
            errors++;
            $display("FAIL cnt_after_clear: cnt=%0d, want 1", bus_s.sbit_cnt_o);
        end
        $display("test_saturation done");
    endtask

    task automatic test_random();
        flush();
        for (int i = 0; i < 400; i++) begin
            sb_drv   = {$urandom() & $urandom() & $urandom(), $urandom() & $urandom()};
            dt_drv   = 4'($urandom_range(0, 15));
            al_drv   = ($urandom_range(0, 19) != 0);
            un_drv   = ($urandom_range(0, 29) == 0);
            mk_drv   = ($urandom_range(0, 29) == 0);
            crst_drv = ($urandom_range(0, 49) == 0);
            tick();
            vectors++;
            if (bus_a.sbits_o !== m_out || bus_a.active_o !== m_act ||
                bus_a.sbit_cnt_o !== m_cnt || bus_s.sbit_cnt_o !== m_cnt_s) begin
                errors++;
                $display("FAIL random[%0d]: sbits_o=%h act=%b cnt=%0d/%0d, want %h %b %0d/%0d", i,
                         bus_a.sbits_o, bus_a.active_o, bus_a.sbit_cnt_o, bus_s.sbit_cnt_o,
                         m_out, m_act, m_cnt, m_cnt_s);
            end
        end
        un_drv = 1'b0; mk_drv = 1'b0; crst_drv = 1'b0;
        $display("test_random done");
    endtask

    task automatic test_reset_midtraffic();
        flush();
        dt_drv = 4'd15; sb_drv = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        vectors++;
        if (bus_a.sbits_o !== 64'h0 || bus_a.active_o !== 1'b0 || bus_a.sbit_cnt_o !== 24'h0) begin
            errors++;
            $display("FAIL reset_mid: sbits_o=%h active_o=%b cnt=%0d, want 0/0/0",
                     bus_a.sbits_o, bus_a.active_o, bus_a.sbit_cnt_o);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (bus_a.sbits_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_release_1: sbits_o=%h, want 0", bus_a.sbits_o);
        end
        tick();
        vectors++;
        if (bus_a.sbits_o !== 64'hFFFF_FFFF_FFFF_FFFF || bus_a.sbits_o !== m_out) begin
            errors++;
            $display("FAIL reset_release_2: sbits_o=%h, want all ones", bus_a.sbits_o);
        end
        $display("test_reset_midtraffic done");
    endtask

    initial begin
        reset = 1'b1; sb_drv = '0; al_drv = 1'b0; un_drv = 1'b0; mk_drv = 1'b0;
        crst_drv = 1'b0; dt_drv = 4'd0;
        m_sr = '0; m_en = 1'b0; m_out = '0; m_act = 1'b0; m_cnt = '0; m_cnt_s = '0;
        for (int c = 0; c < 64; c++) blocked[c] = 0;
        test_reset();
        test_passthrough();
        test_deadtime_hold();
        test_independent();
        test_disable();
        test_saturation();
        test_random();
        test_reset_midtraffic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
